// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the CPU/DMA NMI arbiter.
package nmi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TOUT = 2'd2
  } arb_state_e;

  // Owner encoding is one-hot so it can drive grant_o directly.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // DMA normally wins; a waiting CPU that has been passed over too often wins instead.
  function automatic logic [1:0] pick_owner(input logic cpu_valid,
                                            input logic dma_valid,
                                            input logic cpu_starved);
    if (dma_valid && !(cpu_valid && cpu_starved)) begin
      return OWN_DMA;
    end else if (cpu_valid) begin
      return OWN_CPU;
    end else begin
      return OWN_NONE;
    end
  endfunction

endpackage

// File: rtl/nmi_arb_wdt.sv
// Slave-ready watchdog: counts stalled transfer cycles and flags the last allowed one.
module nmi_arb_wdt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q;

  // Stall counter, restarted for every new transfer and held once it reaches the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST_COUNT)) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Expiry only counts in a stalled cycle, so a coincident slave ready never times out.
  assign expire_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/nmi_dma_arb.sv
// Two-master (CPU, DMA) NMI arbiter in front of a single native IP decoder.
module nmi_dma_arb
  import nmi_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT   = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        cpu_valid_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wstrb_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,

  input  logic        dma_valid_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_wstrb_i,
  output logic        dma_ready_o,
  output logic [31:0] dma_rdata_o,

  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_q;
  logic [1:0]    grant_q;
  logic [SW-1:0] starve_q;
  logic          timeout_q;

  logic          any_valid;
  logic          cpu_starved;
  logic [1:0]    winner;
  logic          owner_valid;
  logic [31:0]   owner_addr;
  logic [31:0]   owner_wdata;
  logic [3:0]    owner_wstrb;
  logic          xfer_live;
  logic          xfer_done;
  logic          tout_live;
  logic          wdt_clear;
  logic          wdt_enable;
  logic          wdt_expire;

  assign any_valid   = cpu_valid_i | dma_valid_i;
  assign cpu_starved = (starve_q == STARVE_MAX);
  assign winner      = pick_owner(cpu_valid_i, dma_valid_i, cpu_starved);

  // Select the current owner's request; nothing is selected while idle.
  always_comb begin
    owner_valid = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    owner_wstrb = '0;
    case (grant_q)
      OWN_CPU: begin
        owner_valid = cpu_valid_i;
        owner_addr  = cpu_addr_i;
        owner_wdata = cpu_wdata_i;
        owner_wstrb = cpu_wstrb_i;
      end
      OWN_DMA: begin
        owner_valid = dma_valid_i;
        owner_addr  = dma_addr_i;
        owner_wdata = dma_wdata_i;
        owner_wstrb = dma_wstrb_i;
      end
      default: begin
        owner_valid = 1'b0;
      end
    endcase
  end

  // The slave request depends only on state and master valid, never on s_ready_i.
  assign xfer_live = !rst_i && (state_q == ST_XFER) && owner_valid;
  assign xfer_done = xfer_live && s_ready_i;
  assign tout_live = !rst_i && (state_q == ST_TOUT);

  assign s_valid_o = xfer_live;
  assign s_addr_o  = xfer_live ? owner_addr  : '0;
  assign s_wdata_o = xfer_live ? owner_wdata : '0;
  assign s_wstrb_o = xfer_live ? owner_wstrb : '0;

  assign cpu_ready_o = grant_q[0] && (xfer_done || tout_live);
  assign dma_ready_o = grant_q[1] && (xfer_done || tout_live);
  assign cpu_rdata_o = !grant_q[0] ? '0 : (xfer_done ? s_rdata_i : (tout_live ? ERR_RDATA : '0));
  assign dma_rdata_o = !grant_q[1] ? '0 : (xfer_done ? s_rdata_i : (tout_live ? ERR_RDATA : '0));

  assign grant_o   = rst_i ? OWN_NONE : grant_q;
  assign timeout_o = !rst_i && timeout_q;

  assign wdt_clear  = (state_q == ST_IDLE) && any_valid;
  assign wdt_enable = (state_q == ST_XFER) && owner_valid && !s_ready_i;

  nmi_arb_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (wdt_clear),
    .enable_i(wdt_enable),
    .expire_o(wdt_expire)
  );

  // Arbitration FSM: grant in IDLE, run one transfer, optionally report a timeout, back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= OWN_NONE;
      starve_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            grant_q <= winner;
            state_q <= ST_XFER;
            if (winner == OWN_CPU) begin
              starve_q <= '0;
            end else if (cpu_valid_i && !cpu_starved) begin
              starve_q <= starve_q + SW'(1);
            end
          end
        end
        ST_XFER: begin
          if (!owner_valid || s_ready_i) begin
            state_q <= ST_IDLE;
            grant_q <= OWN_NONE;
          end else if (wdt_expire) begin
            state_q   <= ST_TOUT;
            timeout_q <= 1'b1;
          end
        end
        ST_TOUT: begin
          state_q <= ST_IDLE;
          grant_q <= OWN_NONE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
